// File: rtl/eh2_dec_gpr_wb_arb.sv
// Write-back arbiter for a two-port GPR slice. Pipe writes (i0, i1) always
// issue immediately. Late writes from the load-return and divider paths are
// held in an in-order queue and drained onto whichever ports the pipes leave
// idle. Stale late writes are killed by younger pipe writes to the same
// (tid, addr), and a per-thread pending bitmap is exported for the scoreboard.
module eh2_dec_gpr_wb_arb #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i0_wen,
   input  logic [4:0]  i0_waddr,
   input  logic        i0_wtid,
   input  logic [31:0] i0_wd,
   input  logic        i1_wen,
   input  logic [4:0]  i1_waddr,
   input  logic        i1_wtid,
   input  logic [31:0] i1_wd,
   input  logic        nb_valid,
   output logic        nb_ready,
   input  logic [4:0]  nb_waddr,
   input  logic        nb_wtid,
   input  logic [31:0] nb_wd,
   input  logic        div_valid,
   output logic        div_ready,
   input  logic [4:0]  div_waddr,
   input  logic        div_wtid,
   input  logic [31:0] div_wd,
   output logic        wen0,
   output logic [4:0]  waddr0,
   output logic        wtid0,
   output logic [31:0] wd0,
   output logic        wen1,
   output logic [4:0]  waddr1,
   output logic        wtid1,
   output logic [31:0] wd1,
   output logic [63:0] pend_vec,
   output logic [3:0]  fifo_count
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [3:0] DEPTH = 4'(FIFO_DEPTH);

   logic [PW-1:0] head, tail, head_n, tail_n2;
   logic [3:0]    count, count_next, pushes, pops;
   logic          q_live [FIFO_DEPTH];
   logic          q_tid  [FIFO_DEPTH];
   logic [4:0]    q_addr [FIFO_DEPTH];
   logic [31:0]   q_data [FIFO_DEPTH];
   logic          kill_q [FIFO_DEPTH];

   logic       i0_live, i1_live, nb_hit, div_hit, push_nb, push_div;
   logic [1:0] free, free_n;
   logic       h_valid, n_valid, h_live, n_live, h_pop, n_pop, h_issue, n_issue, n_same;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign i0_live = i0_wen & (i0_waddr != 5'd0);
   assign i1_live = i1_wen & (i1_waddr != 5'd0);
   assign nb_hit  = (i0_live & (nb_wtid == i0_wtid) & (nb_waddr == i0_waddr)) |
                    (i1_live & (nb_wtid == i1_wtid) & (nb_waddr == i1_waddr));
   assign div_hit = (i0_live & (div_wtid == i0_wtid) & (div_waddr == i0_waddr)) |
                    (i1_live & (div_wtid == i1_wtid) & (div_waddr == i1_waddr));

   // Readies use the registered count only; same-cycle pops never make room.
   assign nb_ready  = ~rst & (count < DEPTH);
   assign div_ready = ~rst & ((count < DEPTH - 4'd1) | ((count < DEPTH) & ~nb_valid));
   assign push_nb   = nb_valid & nb_ready;
   assign push_div  = div_valid & div_ready;

   // Queued entries matching a live pipe write this cycle are stale.
   always_comb begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         kill_q[i] = q_live[i] &
                     ((i0_live & (q_tid[i] == i0_wtid) & (q_addr[i] == i0_waddr)) |
                      (i1_live & (q_tid[i] == i1_wtid) & (q_addr[i] == i1_waddr)));
      end
   end

   assign head_n  = inc(head);
   assign tail_n2 = inc(tail);
   assign h_valid = (count != 4'd0);
   assign n_valid = (count >= 4'd2);
   assign h_live  = h_valid & q_live[head] & ~kill_q[head];
   assign n_live  = n_valid & q_live[head_n] & ~kill_q[head_n];
   assign free    = 2'd2 - {1'b0, i0_live} - {1'b0, i1_live};
   assign h_pop   = h_valid & (~h_live | (free != 2'd0));
   assign h_issue = h_pop & h_live;
   assign free_n  = free - {1'b0, h_issue};
   // Same (tid, addr) on both ports would be ambiguous; N waits a cycle.
   assign n_same  = h_issue & (q_tid[head_n] == q_tid[head]) & (q_addr[head_n] == q_addr[head]);
   assign n_pop   = h_pop & n_valid & (~n_live | ((free_n != 2'd0) & ~n_same));
   assign n_issue = n_pop & n_live;

   assign pushes     = {3'd0, push_nb} + {3'd0, push_div};
   assign pops       = {3'd0, h_pop} + {3'd0, n_pop};
   assign count_next = count + pushes - pops;
   assign fifo_count = count;

   // Pack the up-to-four write candidates, in priority order, onto the lowest free port.
   always_comb begin
      logic        cv [4];
      logic        ct [4];
      logic [4:0]  ca [4];
      logic [31:0] cd [4];
      cv[0] = i0_live; ct[0] = i0_wtid;      ca[0] = i0_waddr;     cd[0] = i0_wd;
      cv[1] = i1_live; ct[1] = i1_wtid;      ca[1] = i1_waddr;     cd[1] = i1_wd;
      cv[2] = h_issue; ct[2] = q_tid[head];  ca[2] = q_addr[head]; cd[2] = q_data[head];
      cv[3] = n_issue; ct[3] = q_tid[head_n]; ca[3] = q_addr[head_n]; cd[3] = q_data[head_n];
      wen0 = 1'b0; waddr0 = '0; wtid0 = 1'b0; wd0 = '0;
      wen1 = 1'b0; waddr1 = '0; wtid1 = 1'b0; wd1 = '0;
      for (int k = 0; k < 4; k++) begin
         if (cv[k] && !rst) begin
            if (!wen0) begin
               wen0 = 1'b1; waddr0 = ca[k]; wtid0 = ct[k]; wd0 = cd[k];
            end else if (!wen1) begin
               wen1 = 1'b1; waddr1 = ca[k]; wtid1 = ct[k]; wd1 = cd[k];
            end
         end
      end
   end

   // Pending bitmap is decoded purely from the queue registers.
   always_comb begin
      pend_vec = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (q_live[i]) pend_vec[{q_tid[i], q_addr[i]}] = 1'b1;
      end
   end

   // Queue state: kill, pop, then push (push slots are never occupied).
   always_ff @(posedge clk) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) q_live[i] <= 1'b0;
      end else begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (kill_q[i]) q_live[i] <= 1'b0;
         end
         if (h_pop) q_live[head] <= 1'b0;
         if (n_pop) q_live[head_n] <= 1'b0;
         if (push_nb) begin
            q_live[tail] <= (nb_waddr != 5'd0) & ~nb_hit;
            q_tid[tail]  <= nb_wtid;
            q_addr[tail] <= nb_waddr;
            q_data[tail] <= nb_wd;
         end
         if (push_div) begin
            q_live[push_nb ? tail_n2 : tail] <= (div_waddr != 5'd0) & ~div_hit;
            q_tid[push_nb ? tail_n2 : tail]  <= div_wtid;
            q_addr[push_nb ? tail_n2 : tail] <= div_waddr;
            q_data[push_nb ? tail_n2 : tail] <= div_wd;
         end
         head  <= n_pop ? inc(head_n) : (h_pop ? head_n : head);
         tail  <= (push_nb & push_div) ? inc(tail_n2) : ((push_nb | push_div) ? tail_n2 : tail);
         count <= count_next;
      end
   end

   // Interface invariants.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(i0_live && i1_live && (i0_wtid == i1_wtid) && (i0_waddr == i1_waddr)));
         assert (pops <= count);
         assert (count + pushes <= DEPTH);
      end
   end

endmodule

// File: tb/tb_eh2_dec_gpr_wb_arb.sv
// Directed bench for eh2_dec_gpr_wb_arb: vector table for pipe port
// steering, plus hand-written sequences for queueing, kill and reset.
module tb_eh2_dec_gpr_wb_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        i0_wen, i1_wen, i0_wtid, i1_wtid;
   logic [4:0]  i0_waddr, i1_waddr;
   logic [31:0] i0_wd, i1_wd;
   logic        nb_valid, nb_ready, nb_wtid;
   logic [4:0]  nb_waddr;
   logic [31:0] nb_wd;
   logic        div_valid, div_ready, div_wtid;
   logic [4:0]  div_waddr;
   logic [31:0] div_wd;
   logic        wen0, wen1, wtid0, wtid1;
   logic [4:0]  waddr0, waddr1;
   logic [31:0] wd0, wd1;
   logic [63:0] pend_vec;
   logic [3:0]  fifo_count;

   int tests = 0;
   int fails = 0;

   eh2_dec_gpr_wb_arb #(.FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .i0_wen(i0_wen), .i0_waddr(i0_waddr), .i0_wtid(i0_wtid), .i0_wd(i0_wd),
      .i1_wen(i1_wen), .i1_waddr(i1_waddr), .i1_wtid(i1_wtid), .i1_wd(i1_wd),
      .nb_valid(nb_valid), .nb_ready(nb_ready), .nb_waddr(nb_waddr), .nb_wtid(nb_wtid), .nb_wd(nb_wd),
      .div_valid(div_valid), .div_ready(div_ready), .div_waddr(div_waddr), .div_wtid(div_wtid), .div_wd(div_wd),
      .wen0(wen0), .waddr0(waddr0), .wtid0(wtid0), .wd0(wd0),
      .wen1(wen1), .waddr1(waddr1), .wtid1(wtid1), .wd1(wd1),
      .pend_vec(pend_vec), .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic w0; logic [4:0] a0; logic t0; logic [31:0] d0;
      logic w1; logic [4:0] a1; logic t1; logic [31:0] d1;
      logic [38:0] p0; logic [38:0] p1;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_ports(input string name, input logic [38:0] e0, input logic [38:0] e1);
      chk({name, "_p0"}, {25'd0, wen0, wtid0, waddr0, wd0}, {25'd0, e0});
      chk({name, "_p1"}, {25'd0, wen1, wtid1, waddr1, wd1}, {25'd0, e1});
   endtask

   task automatic pipes(input logic w0, input logic [4:0] a0, input logic t0, input logic [31:0] d0,
                        input logic w1, input logic [4:0] a1, input logic t1, input logic [31:0] d1);
      i0_wen = w0; i0_waddr = a0; i0_wtid = t0; i0_wd = d0;
      i1_wen = w1; i1_waddr = a1; i1_wtid = t1; i1_wd = d1;
   endtask

   task automatic nb(input logic v, input logic [4:0] a, input logic t, input logic [31:0] d);
      nb_valid = v; nb_waddr = a; nb_wtid = t; nb_wd = d;
   endtask

   task automatic dv(input logic v, input logic [4:0] a, input logic t, input logic [31:0] d);
      div_valid = v; div_waddr = a; div_wtid = t; div_wd = d;
   endtask

   task automatic busy();
      pipes(1, 5'd1, 0, 32'h1111, 1, 5'd2, 0, 32'h2222);
   endtask

   task automatic idle();
      pipes(0, 5'd0, 0, 32'h0, 0, 5'd0, 0, 32'h0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   localparam logic [38:0] Z = 39'd0;

   function automatic logic [38:0] pw(input logic [4:0] a, input logic t, input logic [31:0] d);
      return {1'b1, t, a, d};
   endfunction

   initial begin
      vecs[0] = '{0, 5'd0, 0, 32'h0,  0, 5'd0, 0, 32'h0,  Z, Z};
      vecs[1] = '{1, 5'd1, 0, 32'd11, 0, 5'd0, 0, 32'h0,  {1'b1, 1'b0, 5'd1, 32'd11}, Z};
      vecs[2] = '{0, 5'd0, 0, 32'h0,  1, 5'd2, 1, 32'd22, {1'b1, 1'b1, 5'd2, 32'd22}, Z};
      vecs[3] = '{1, 5'd3, 0, 32'd33, 1, 5'd4, 1, 32'd44, {1'b1, 1'b0, 5'd3, 32'd33}, {1'b1, 1'b1, 5'd4, 32'd44}};
      vecs[4] = '{1, 5'd0, 0, 32'd99, 1, 5'd5, 0, 32'd55, {1'b1, 1'b0, 5'd5, 32'd55}, Z};
      vecs[5] = '{1, 5'd0, 1, 32'd1,  1, 5'd0, 0, 32'd2,  Z, Z};
      vecs[6] = '{1, 5'd9, 1, 32'hDEAD, 0, 5'd0, 0, 32'h0, {1'b1, 1'b1, 5'd9, 32'hDEAD}, Z};

      rst = 1'b1;
      idle(); nb(0, 0, 0, 0); dv(0, 0, 0, 0);
      tick(); tick();
      // Reset gates the ports even with a live pipe write.
      pipes(1, 5'd1, 0, 32'h1, 0, 5'd0, 0, 32'h0);
      #3;
      chk_ports("rst_gate", Z, Z);
      chk("rst_count", {60'd0, fifo_count}, 64'd0);
      chk("rst_pend", pend_vec, 64'd0);
      tick();
      rst = 1'b0;
      idle();

      // Pipe steering table, queue empty throughout.
      for (int v = 0; v < 7; v++) begin
         pipes(vecs[v].w0, vecs[v].a0, vecs[v].t0, vecs[v].d0,
               vecs[v].w1, vecs[v].a1, vecs[v].t1, vecs[v].d1);
         #3;
         chk_ports($sformatf("vec%0d", v), vecs[v].p0, vecs[v].p1);
         chk($sformatf("vec%0d_rdy", v), {62'd0, nb_ready, div_ready}, 64'd3);
         chk($sformatf("vec%0d_cnt", v), {60'd0, fifo_count}, 64'd0);
         tick();
      end
      idle();

      // Single load return: one-cycle latency, pending pulse.
      nb(1, 5'd5, 0, 32'hA5);
      #3;
      chk("s1_ready", {63'd0, nb_ready}, 64'd1);
      chk_ports("s1_push", Z, Z);
      tick();
      nb(0, 0, 0, 0);
      #3;
      chk_ports("s1_issue", pw(5'd5, 0, 32'hA5), Z);
      chk("s1_cnt1", {60'd0, fifo_count}, 64'd1);
      chk("s1_pend", pend_vec, 64'd1 << 5);
      tick();
      #3;
      chk("s1_cnt0", {60'd0, fifo_count}, 64'd0);
      chk("s1_pend0", pend_vec, 64'd0);
      chk_ports("s1_after", Z, Z);
      tick();

      // Fill while pipes own both ports, then drain two per cycle.
      busy(); nb(1, 5'd10, 0, 32'h10A);
      #3;
      chk_ports("s2_c1", pw(5'd1, 0, 32'h1111), pw(5'd2, 0, 32'h2222));
      tick();
      nb(1, 5'd11, 0, 32'h10B); dv(1, 5'd12, 0, 32'h10C);
      #3;
      chk("s2_c2_cnt", {60'd0, fifo_count}, 64'd1);
      chk("s2_c2_rdy", {62'd0, nb_ready, div_ready}, 64'd3);
      tick();
      nb(1, 5'd13, 0, 32'h10D); dv(1, 5'd14, 0, 32'h10E);
      #3;
      chk("s2_c3_cnt", {60'd0, fifo_count}, 64'd3);
      chk("s2_c3_rdy", {62'd0, nb_ready, div_ready}, 64'd2);
      tick();
      idle(); nb(0, 0, 0, 0); dv(0, 0, 0, 0);
      #3;
      chk("s2_full_cnt", {60'd0, fifo_count}, 64'd4);
      chk("s2_full_rdy", {62'd0, nb_ready, div_ready}, 64'd0);
      chk("s2_pend", pend_vec, 64'h3C00);
      chk_ports("s2_d1", pw(5'd10, 0, 32'h10A), pw(5'd11, 0, 32'h10B));
      tick();
      #3;
      chk("s2_d2_cnt", {60'd0, fifo_count}, 64'd2);
      chk_ports("s2_d2", pw(5'd12, 0, 32'h10C), pw(5'd13, 0, 32'h10D));
      tick();
      #3;
      chk("s2_d3_cnt", {60'd0, fifo_count}, 64'd0);
      chk_ports("s2_d3", Z, Z);
      tick();

      // Kill: younger pipe write to the same (tid, addr) wins.
      busy(); nb(1, 5'd7, 1, 32'h77);
      tick();
      nb(0, 0, 0, 0);
      pipes(1, 5'd7, 1, 32'h99, 1, 5'd2, 0, 32'h22);
      #3;
      chk("s3_pend", pend_vec, 64'd1 << 39);
      chk("s3_cnt", {60'd0, fifo_count}, 64'd1);
      chk_ports("s3_kill", pw(5'd7, 1, 32'h99), pw(5'd2, 0, 32'h22));
      tick();
      idle();
      #3;
      chk("s3_pend0", pend_vec, 64'd0);
      chk("s3_cnt0", {60'd0, fifo_count}, 64'd0);
      chk_ports("s3_after", Z, Z);
      tick();

      // H and N to the same register: N waits one cycle.
      busy(); nb(1, 5'd3, 0, 32'h31); dv(1, 5'd3, 0, 32'h32);
      tick();
      idle(); nb(0, 0, 0, 0); dv(0, 0, 0, 0);
      #3;
      chk("s4_cnt2", {60'd0, fifo_count}, 64'd2);
      chk_ports("s4_h", pw(5'd3, 0, 32'h31), Z);
      tick();
      #3;
      chk("s4_cnt1", {60'd0, fifo_count}, 64'd1);
      chk_ports("s4_n", pw(5'd3, 0, 32'h32), Z);
      tick();
      #3;
      chk("s4_cnt0", {60'd0, fifo_count}, 64'd0);
      tick();

      // Enqueue to x0: accepted, never written.
      nb(1, 5'd0, 0, 32'h55);
      tick();
      nb(0, 0, 0, 0);
      #3;
      chk("s5_cnt1", {60'd0, fifo_count}, 64'd1);
      chk("s5_pend", pend_vec, 64'd0);
      chk_ports("s5_nowr", Z, Z);
      tick();
      #3;
      chk("s5_cnt0", {60'd0, fifo_count}, 64'd0);
      tick();

      // Reset with three entries queued.
      busy(); nb(1, 5'd20, 0, 32'h20); dv(1, 5'd21, 1, 32'h21);
      tick();
      nb(1, 5'd22, 0, 32'h22); dv(0, 0, 0, 0);
      #3;
      chk("s6_cnt2", {60'd0, fifo_count}, 64'd2);
      tick();
      nb(0, 0, 0, 0);
      rst = 1'b1;
      #3;
      chk("s6_cnt3", {60'd0, fifo_count}, 64'd3);
      chk("s6_pend3", pend_vec, (64'd1 << 20) | (64'd1 << 53) | (64'd1 << 22));
      chk_ports("s6_rst", Z, Z);
      tick();
      rst = 1'b0;
      idle();
      #3;
      chk("s6_cnt0", {60'd0, fifo_count}, 64'd0);
      chk("s6_pend0", pend_vec, 64'd0);
      chk_ports("s6_post1", Z, Z);
      tick();
      #3;
      chk_ports("s6_post2", Z, Z);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/eh2_dec_gpr_wb_arb.md
Name: eh2_dec_gpr_wb_arb

Overview:
- Write-back scheduler in front of a two-write-port slice of the GPR file.
- Pipe results (i0, i1) have fixed priority and are never stalled.
- Late results (non-blocking load return, divider) are queued in a shared in-order FIFO and drained onto whichever write ports the pipes leave idle.
- Also resolves write-after-write ordering by killing stale late writes, and exports a per-thread pending-write bitmap for the dependency scoreboard.

Parameters:
- FIFO_DEPTH, 4, late-write queue entries; legal range 2..8.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i0_wen, i1_wen  in  1  pipe write valid
- i0_waddr, i1_waddr  in  5  pipe destination register
- i0_wtid, i1_wtid  in  1  pipe thread id
- i0_wd, i1_wd  in  32  pipe write data
- nb_valid  in  1  load-return write request
- nb_ready  out  1  load-return accepted when valid & ready
- nb_waddr  in  5  load-return destination
- nb_wtid  in  1  load-return thread id
- nb_wd  in  32  load-return data
- div_valid  in  1  divider write request
- div_ready  out  1  divider accepted when valid & ready
- div_waddr  in  5  divider destination
- div_wtid  in  1  divider thread id
- div_wd  in  32  divider data
- wen0, wen1  out  1  GPR write-port enables
- waddr0, waddr1  out  5  GPR write-port addresses
- wtid0, wtid1  out  1  GPR write-port thread ids
- wd0, wd1  out  32  GPR write-port data
- pend_vec  out  64  bit tid*32+addr set while a live queued write exists
- fifo_count  out  4  registered occupancy

Behaviour:
- Reset (synchronous):
  - Clears the FIFO, count, pointers and pend_vec.
  - Port outputs are combinational and are 0 while rst is high.
  - Reset mid-operation discards all queued writes without issuing them.
- Pipe writes:
  - A pipe write with waddr==0 is ignored entirely: no port used, no kill.
  - i0 takes port0 if valid; i1 takes the lowest port not used by i0.
  - Pipe writes issue in the same cycle, combinationally; latency 0.
- Free ports = 2 minus the number of live pipe writes.
- Enqueue:
  - nb_ready = count < FIFO_DEPTH.
  - div_ready = (count < FIFO_DEPTH-1) | (count < FIFO_DEPTH & ~nb_valid).
  - count is the registered value; same-cycle pops do not create room.
  - When both are accepted in one cycle, nb is enqueued before div.
  - Each entry stores {live, tid, addr, data}.
  - live = 0 if addr==0 or if (tid, addr) matches a same-cycle live pipe write.
- Kill:
  - Any queued live entry whose (tid, addr) matches a live pipe write in the current cycle is cleared to live=0 at the clock edge.
  - The pipe write is younger and wins.
- Drain:
  - Examines head (H) and head+1 (N) as registered at the start of the cycle.
  - Entries being killed this cycle count as dead.
  - H pops if dead (no port used) or if a free port exists; a live H uses the lowest free port.
  - N pops only if H popped, and N is dead or a port remains free.
  - A live N does not issue when its (tid, addr) equals a live H issuing in the same cycle; it waits.
  - Maximum two pops per cycle; minimum enqueue-to-write latency is 1 cycle.
  - Order is strict FIFO; a live entry never bypasses an older entry.
- Count: count_next = count + pushes - pops.
  - Push and pop in the same cycle are legal.
  - Pointers wrap modulo FIFO_DEPTH.
- pend_vec: OR over live entries, registered (reflects state after the edge).
- Port outputs:
  - When a port is unused, its wen is 0 and its addr/tid/data are 0.
  - The two ports never carry the same live (tid, addr) in one cycle.
- Assertions:
  - i0 and i1 never write the same nonzero (tid, addr) in one cycle.
  - Overflow and underflow never occur.

Test Plan:
- Reset, then nb_valid with addr 5, tid 0, data 0xA5, no pipe traffic → nb_ready=1. Next cycle: wen0=1, waddr0=5, wd0=0xA5; fifo_count 1→0; pend_vec[5] pulses for one cycle.
- i0 and i1 valid for 3 cycles while nb and div both push → FIFO fills to 4. nb_ready=0 when count=4. div_ready=0 at count=3 with nb_valid=1. After the pipes go idle, two entries drain per cycle in push order.
- Queue nb addr 7 tid 1, then i0 writes addr 7 tid 1 while the entry is queued → entry killed: pend_vec[39] clears and the entry later pops with no wen. The pipe data is the only write to r7.
- H and N both target addr 3 tid 0 with both ports free → only H issues on port0. N issues on port0 the following cycle.
- Enqueue with waddr=0 → accepted, never written, count returns to 0. Assert rst with 3 entries queued → count=0, pend_vec=0, no writes follow.
